out_byte_packer: RTL and testbench
==================================

Name: out_byte_packer

Overview:
- Sits directly upstream of the core's UART transmit top. Converts the core's `out` instruction writes into the byte stream that the transmit top consumes.
- Each write is either a single byte or a 32-bit word emitted MSB-first as four bytes.
- Writes are queued in a small word FIFO. The FIFO drains as a gap-free stream of one-cycle Tx_start pulses, at most one byte per cycle.
- Applies backpressure to the core only through its own FIFO. The downstream ring buffer has no ready signal and accepts one byte per cycle unconditionally.

Parameters:
- DEPTH, 8, number of queued write entries; must be a power of two.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- out_valid  in  1  core presents a write.
- out_data  in  32  payload; only bits [7:0] are used when out_len=0.
- out_len  in  1  0 = single byte, 1 = four bytes, big-endian.
- out_ready  out  1  FIFO can accept; equals !full.
- tx_start  out  1  one-cycle byte strobe to the transmit top's Tx_start.
- tx_data  out  8  byte qualified by tx_start.
- busy  out  1  FIFO non-empty or emitter not IDLE.
- byte_count  out  32  total bytes emitted since reset; wraps modulo 2^32.

Behaviour:
- Reset is asynchronous (rstn low), effective immediately:
  - tx_start=0, tx_data=0, byte_count=0, busy=0.
  - FIFO pointers and count = 0, so out_ready=1.
  - Emitter returns to IDLE.
  - Any partially emitted word is discarded with no trailing bytes. Deassertion takes effect at the next clk edge.
- Push: on an edge with out_valid && out_ready, {out_len, out_data} is written at wr_ptr, and wr_ptr and count increment.
  - If out_valid is high while out_ready=0, the write is not taken; the core must hold it.
- Full/empty:
  - out_ready = (count != DEPTH). This is registered-count based, so a pop in the same cycle does not open a slot until the next cycle.
  - A push into an empty FIFO is not visible to the emitter until the following cycle.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH; count is ADDR_W+1 bits wide.
- Emitter FSM states: IDLE, EMIT.
  - IDLE: if count != 0, pop the head into a 32-bit shift register and set bytes_left = out_len ? 4 : 1, then go to EMIT. Otherwise stay in IDLE. tx_start=0 while in IDLE.
  - EMIT, each cycle:
    - tx_start=1.
    - tx_data = shift[31:24] for word entries, or shift[7:0] for byte entries.
    - Shift left by 8 and decrement bytes_left.
    - byte_count increments by 1.
  - Last byte (bytes_left==1): if count != 0 in the same cycle, pop the next entry and stay in EMIT, with no gap between words. Otherwise return to IDLE.
- tx_start and tx_data are registered outputs. tx_data holds its last value when tx_start=0.
- Latency: with the FIFO empty and the emitter in IDLE, a write accepted at edge E0 is popped at E1, and tx_start is high from E2.
  - A word occupies four consecutive tx_start cycles; a byte occupies one.
- Throughput is one byte per cycle sustained, which equals the downstream acceptance rate. The downstream 50000-entry ring buffer overflow is the core program's responsibility and is not detected here.
- busy deasserts in the cycle after the final tx_start when the FIFO is empty.

Decomposition:
- Shared package `out_pkg`:
  - localparams LEN_BYTE=1'b0 and LEN_WORD=1'b1.
  - Emitter state encoding: S_IDLE=1'b0, S_EMIT=1'b1.
  - Entry width ENTRY_W=33.
- One natural sub-module: `word_fifo`, a synchronous FIFO parameterised by DEPTH/ADDR_W with width ENTRY_W.
  - Ports: clk, rstn, push, din, pop, dout, count, full, empty.
  - dout is combinational from the head entry.
- out_byte_packer contains the FSM, the shift register, and byte_count.

Test Plan:
- Single word: after reset, one write with out_len=1, out_data=32'h41424344. Expect:
  - tx_start high for exactly 4 consecutive cycles starting 2 edges after acceptance.
  - tx_data = 41, 42, 43, 44.
  - byte_count = 4, then busy falls.
- Mixed back-to-back: byte 8'h0A with out_len=0, then word 32'h01020304, then byte 8'hFF on consecutive cycles. Expect:
  - 6 contiguous tx_start cycles with no gap.
  - tx_data = 0A, 01, 02, 03, 04, FF.
- Full FIFO: hold out_valid for 12 words of 32'hDEAD0000+i with the emitter running. Expect:
  - out_ready drops when count reaches 8.
  - No writes are lost or duplicated.
  - 48 bytes emitted in order; byte_count = 48.
- Simultaneous push and pop: keep the FIFO at count=1 while the emitter pops. Expect count stays at 1, pointers wrap past 7→0 correctly, and the data order is preserved.
- Reset mid-word: assert rstn=0 asynchronously after the 2nd byte of 32'hCAFEBABE. Expect:
  - tx_start=0 immediately, with no clock edge needed.
  - byte_count=0 and out_ready=1.
  - After release, the FIFO is empty and no further bytes appear.
- byte_count wrap: force byte_count to 32'hFFFFFFFF, then emit one byte. Expect byte_count reads 0.

Source files
------------

// File: rtl/out_pkg.sv
// Shared types and constants for the out-instruction byte packer.
`default_nettype none

package out_pkg;

  localparam logic LEN_BYTE = 1'b0;
  localparam logic LEN_WORD = 1'b1;

  // FIFO entry layout: {len, data[31:0]}
  localparam int ENTRY_W = 33;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } emit_state_e;

  function automatic logic [2:0] bytes_for_len(input logic len);
    return (len == LEN_WORD) ? 3'd4 : 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_byte_packer_word_fifo.sv
// Synchronous word FIFO with registered occupancy count and combinational head output.
`default_nettype none

module word_fifo
  import out_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are ADDR_W wide, so wrap modulo DEPTH falls out of the arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/out_byte_packer.sv
// Packs core `out` writes (byte or big-endian word) into a gap-free Tx_start byte stream.
`default_nettype none

module out_byte_packer
  import out_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        out_valid,
  input  logic [31:0] out_data,
  input  logic        out_len,
  output logic        out_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [31:0] byte_count
);

  logic [ENTRY_W-1:0] fifo_dout;
  logic [ADDR_W:0]    fifo_count;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               fifo_pending;

  emit_state_e state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic        len_q, len_d;
  logic [2:0]  bytes_left_q, bytes_left_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] byte_count_q, byte_count_d;

  assign out_ready    = !fifo_full;
  assign fifo_push    = out_valid && out_ready;
  assign fifo_pending = (fifo_count != '0);

  word_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (fifo_push),
    .din  ({out_len, out_data}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    len_d        = len_q;
    bytes_left_d = bytes_left_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    byte_count_d = byte_count_q;
    fifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_pending) begin
          fifo_pop     = 1'b1;
          shift_d      = fifo_dout[31:0];
          len_d        = fifo_dout[32];
          bytes_left_d = bytes_for_len(fifo_dout[32]);
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        tx_start_d   = 1'b1;
        tx_data_d    = (len_q == LEN_WORD) ? shift_q[31:24] : shift_q[7:0];
        shift_d      = shift_q << 8;
        bytes_left_d = bytes_left_q - 3'd1;
        byte_count_d = byte_count_q + 32'd1;
        if (bytes_left_q == 3'd1) begin
          // Chain straight into the next entry so words leave with no idle cycle.
          if (fifo_pending) begin
            fifo_pop     = 1'b1;
            shift_d      = fifo_dout[31:0];
            len_d        = fifo_dout[32];
            bytes_left_d = bytes_for_len(fifo_dout[32]);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      len_q        <= LEN_BYTE;
      bytes_left_q <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      bytes_left_q <= bytes_left_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign byte_count = byte_count_q;
  // The final strobe is still on the wire when the FSM returns to IDLE, so it keeps busy up.
  assign busy       = !fifo_empty || (state_q == S_EMIT) || tx_start_q;

endmodule

`default_nettype wire

// File: tb/tb_out_byte_packer.sv
// Directed self-checking bench for out_byte_packer.
`timescale 1ns/1ps
`default_nettype none

module tb_out_byte_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_len;
  logic        out_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [31:0] byte_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] cap[$];
  int         stamp[$];

  out_byte_packer #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_ready (out_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Byte log used for ordering and contiguity checks.
  always @(negedge clk) begin
    if (rstn && tx_start) begin
      cap.push_back(tx_data);
      stamp.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cap.delete();
    stamp.delete();
    @(negedge clk);
  endtask

  task automatic drive(input logic len, input logic [31:0] data);
    out_valid = 1'b1;
    out_len   = len;
    out_data  = data;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp_w;
    int          i, n;
    logic        saw_full;

    rstn = 1'b0; out_valid = 1'b0; out_data = '0; out_len = 1'b0;
    #1;
    check("rst_tx_start",   {31'd0, tx_start},  32'd0);
    check("rst_tx_data",    {24'd0, tx_data},   32'd0);
    check("rst_byte_count", byte_count,         32'd0);
    check("rst_busy",       {31'd0, busy},      32'd0);
    check("rst_out_ready",  {31'd0, out_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single word: two-edge latency, four strobes MSB first.
    word = 32'h41424344;
    out_valid = 1'b1; out_len = 1'b1; out_data = word;
    @(negedge clk);
    out_valid = 1'b0;
    check("t1_lat_e0", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("t1_lat_e1", {31'd0, tx_start}, 32'd0);
    check("t1_busy",   {31'd0, busy},     32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_strobe", {31'd0, tx_start}, 32'd1);
      check("t1_byte",   {24'd0, tx_data},  {24'd0, word[31-8*k -: 8]});
    end
    @(negedge clk);
    check("t1_strobe_off", {31'd0, tx_start}, 32'd0);
    check("t1_tx_hold",    {24'd0, tx_data},  32'h44);
    check("t1_count",      byte_count,        32'd4);
    check("t1_busy_off",   {31'd0, busy},     32'd0);

    // Mixed back-to-back: byte, word, byte with no gap.
    do_reset();
    out_valid = 1'b1;
    out_len = 1'b0; out_data = 32'h1234560A; @(negedge clk);
    out_len = 1'b1; out_data = 32'h01020304; @(negedge clk);
    out_len = 1'b0; out_data = 32'hABCDEFFF; @(negedge clk);
    out_valid = 1'b0;
    wait_idle(30);
    check("t2_nbytes", cap.size(), 32'd6);
    if (cap.size() == 6) begin
      check("t2_b0", {24'd0, cap[0]}, 32'h0A);
      check("t2_b1", {24'd0, cap[1]}, 32'h01);
      check("t2_b2", {24'd0, cap[2]}, 32'h02);
      check("t2_b3", {24'd0, cap[3]}, 32'h03);
      check("t2_b4", {24'd0, cap[4]}, 32'h04);
      check("t2_b5", {24'd0, cap[5]}, 32'hFF);
      check("t2_contig", stamp[5] - stamp[0], 32'd5);
    end
    check("t2_count", byte_count, 32'd6);

    // Full FIFO: stream 12 words with the core holding each until accepted.
    do_reset();
    i = 0; n = 0; saw_full = 1'b0;
    while (i < 12 && n < 300) begin
      out_valid = 1'b1; out_len = 1'b1; out_data = 32'hDEAD0000 + i;
      if (out_ready) begin
        i++;
      end else begin
        saw_full = 1'b1;
        check("t3_full_count", {28'd0, dut.u_fifo.count}, 32'd8);
      end
      @(negedge clk);
      n++;
    end
    out_valid = 1'b0;
    check("t3_all_taken", i, 32'd12);
    check("t3_saw_full", {31'd0, saw_full}, 32'd1);
    wait_idle(200);
    check("t3_nbytes", cap.size(), 32'd48);
    if (cap.size() == 48) begin
      for (int k = 0; k < 48; k++) begin
        exp_w = 32'hDEAD0000 + k / 4;
        check("t3_byte", {24'd0, cap[k]}, {24'd0, exp_w[31-8*(k%4) -: 8]});
      end
      check("t3_contig", stamp[47] - stamp[0], 32'd47);
    end
    check("t3_count", byte_count, 32'd48);

    // Simultaneous push and pop: occupancy pinned at one across pointer wrap.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      out_valid = 1'b1; out_len = 1'b0; out_data = 32'h00000050 + k;
      @(negedge clk);
      check("t4_count_one", {28'd0, dut.u_fifo.count}, 32'd1);
    end
    out_valid = 1'b0;
    wait_idle(30);
    check("t4_nbytes", cap.size(), 32'd12);
    if (cap.size() == 12) begin
      for (int k = 0; k < 12; k++) check("t4_byte", {24'd0, cap[k]}, 32'h50 + k);
      check("t4_contig", stamp[11] - stamp[0], 32'd11);
    end
    check("t4_count", byte_count, 32'd12);

    // Asynchronous reset in the middle of a word.
    do_reset();
    drive(1'b1, 32'hCAFEBABE);
    n = 0;
    while (cap.size() < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_two_bytes", cap.size(), 32'd2);
    if (cap.size() >= 2) begin
      check("t5_b0", {24'd0, cap[0]}, 32'hCA);
      check("t5_b1", {24'd0, cap[1]}, 32'hFE);
    end
    #1;
    rstn = 1'b0;
    #1;
    check("t5_async_tx_start", {31'd0, tx_start},  32'd0);
    check("t5_async_count",    byte_count,         32'd0);
    check("t5_async_ready",    {31'd0, out_ready}, 32'd1);
    check("t5_async_busy",     {31'd0, busy},      32'd0);
    cap.delete();
    stamp.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_trailing", cap.size(), 32'd0);
    check("t5_fifo_empty",  {28'd0, dut.u_fifo.count}, 32'd0);
    check("t5_count_after", byte_count, 32'd0);

    // byte_count wraps modulo 2^32.
    do_reset();
    force dut.byte_count_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.byte_count_q;
    check("t6_preset", byte_count, 32'hFFFFFFFF);
    drive(1'b0, 32'h0000007E);
    wait_idle(20);
    check("t6_nbytes", cap.size(), 32'd1);
    if (cap.size() == 1) check("t6_byte", {24'd0, cap[0]}, 32'h7E);
    check("t6_wrap", byte_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
